// File: rtl/sram_bridge_pkg.sv
// Shared types and elaboration-time helpers for the parametrised SRAM bridge.
// Width helpers are used in port declarations, so they must stay constant functions.
package sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_DONE
  } state_t;

  localparam int WAIT_W = 4;

  function automatic int ratioOf(input int busW, input int ramW);
    return (ramW > 0) ? busW / ramW : 0;
  endfunction

  // A single-beat bridge has no beat index bits on the SRAM address.
  function automatic int beatWOf(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 0;
  endfunction

  function automatic int idxWOf(input int ratio);
    return (beatWOf(ratio) > 0) ? beatWOf(ratio) : 1;
  endfunction

  function automatic bit paramsLegal(input int busW, input int ramW, input int abw,
                                     input int waitCyc);
    bit ok;
    ok = (ramW == 8) || (ramW == 16) || (ramW == 32);
    ok = ok && (busW > 0) && ((busW % ramW) == 0);
    ok = ok && ((busW / ramW == 1) || (busW / ramW == 2) || (busW / ramW == 4));
    ok = ok && (abw >= 1) && (waitCyc >= 0) && (waitCyc <= 15);
    return ok;
  endfunction

endpackage

// File: rtl/sram_beat_seq.sv
// Beat sequencer: current beat index, per-beat wait counter and a priority
// encoder that finds the first / next beat whose lane group is enabled.
module sram_beat_seq
  import sram_bridge_pkg::*;
#(
  parameter int RATIO    = 2,
  parameter int IDX_W    = 1,
  parameter int WAIT_CYC = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_run,
  input  logic [RATIO-1:0] i_mask,
  output logic [IDX_W-1:0] o_beat,
  output logic             o_waitDone,
  output logic             o_firstValid,
  output logic             o_nextValid
);

  logic [IDX_W-1:0]  r_beat;
  logic [WAIT_W-1:0] r_wait;
  logic [IDX_W-1:0]  w_firstIdx;
  logic [IDX_W-1:0]  w_nextIdx;
  logic              w_firstValid;
  logic              w_nextValid;

  // Scanning downwards leaves the lowest qualifying group as the final winner.
  always_comb begin
    w_firstValid = 1'b0;
    w_firstIdx   = '0;
    w_nextValid  = 1'b0;
    w_nextIdx    = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_firstValid = 1'b1;
        w_firstIdx   = IDX_W'(i);
      end
      if (i_mask[i] && (i > int'(r_beat))) begin
        w_nextValid = 1'b1;
        w_nextIdx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_wait <= '0;
    end else if (i_start) begin
      r_beat <= w_firstIdx;
      r_wait <= WAIT_W'(WAIT_CYC);
    end else if (i_step) begin
      r_beat <= w_nextIdx;
      r_wait <= WAIT_W'(WAIT_CYC);
    end else if (i_run && (r_wait != '0)) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  assign o_beat       = r_beat;
  assign o_waitDone   = (r_wait == '0);
  assign o_firstValid = w_firstValid;
  assign o_nextValid  = w_nextValid;

endmodule

// File: rtl/sram_bridge_n.sv
// Bus-to-async-SRAM bridge: splits one BUS_W access into RATIO narrow beats with
// programmable wait states. Strobes decode from registered state so reset kills them at once.
module sram_bridge_n
  import sram_bridge_pkg::*;
#(
  parameter int BUS_W    = 32,
  parameter int RAM_W    = 16,
  parameter int ABW      = 9,
  parameter int WAIT_CYC = 1
) (
  input  logic                                            clock,
  input  logic                                            rst,
  input  logic [ABW-1:0]                                  address_bus,
  input  logic [BUS_W/8-1:0]                              byteena_bus,
  input  logic [BUS_W-1:0]                                data_bus,
  input  logic                                            wren_bus,
  input  logic                                            ce_bus,
  output logic [BUS_W-1:0]                                q_bus,
  output logic                                            wait_bus,
  output logic [ABW+beatWOf(ratioOf(BUS_W, RAM_W))-1:0]   address_ram,
  output logic [RAM_W/8-1:0]                              byteena_ram,
  output logic [RAM_W-1:0]                                data_ram,
  output logic                                            data_oe_tri,
  output logic                                            wren_ram,
  output logic                                            ce_ram,
  output logic                                            oe_ram,
  input  logic [RAM_W-1:0]                                q_ram
);

  localparam int RATIO  = ratioOf(BUS_W, RAM_W);
  localparam int BEAT_W = beatWOf(RATIO);
  localparam int IDX_W  = idxWOf(RATIO);
  localparam int LANE_B = RAM_W / 8;

  if (!paramsLegal(BUS_W, RAM_W, ABW, WAIT_CYC)) begin : g_badParams
    $error("sram_bridge_n: illegal BUS_W/RAM_W/ABW/WAIT_CYC combination");
  end

  state_t             r_state;
  state_t             w_stateNext;
  logic [ABW-1:0]     r_addr;
  logic [BUS_W-1:0]   r_data;
  logic [BUS_W/8-1:0] r_be;
  logic               r_wren;
  logic [BUS_W-1:0]   r_q;

  logic [RATIO-1:0]   w_maskBus;
  logic [RATIO-1:0]   w_maskLat;
  logic [RATIO-1:0]   w_mask;
  logic [IDX_W-1:0]   w_beat;
  logic               w_waitDone;
  logic               w_firstValid;
  logic               w_nextValid;
  logic               w_start;
  logic               w_step;
  logic               w_run;
  logic               w_accept;
  logic [RAM_W-1:0]   w_dataLane;
  logic [LANE_B-1:0]  w_beLane;

  // Reads use every beat; writes only beats with at least one enabled byte.
  for (genvar g = 0; g < RATIO; g++) begin : g_mask
    assign w_maskBus[g] = ~wren_bus | (|byteena_bus[g*LANE_B +: LANE_B]);
    assign w_maskLat[g] = ~r_wren   | (|r_be[g*LANE_B +: LANE_B]);
  end

  assign w_mask = (r_state == ST_IDLE) ? w_maskBus : w_maskLat;

  sram_beat_seq #(
    .RATIO    (RATIO),
    .IDX_W    (IDX_W),
    .WAIT_CYC (WAIT_CYC)
  ) u_beatSeq (
    .clock        (clock),
    .rst          (rst),
    .i_start      (w_start),
    .i_step       (w_step),
    .i_run        (w_run),
    .i_mask       (w_mask),
    .o_beat       (w_beat),
    .o_waitDone   (w_waitDone),
    .o_firstValid (w_firstValid),
    .o_nextValid  (w_nextValid)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ce_bus) begin
          w_accept = 1'b1;
          if (w_firstValid) begin
            w_start     = 1'b1;
            w_stateNext = ST_BEAT;
          end else begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_BEAT: begin
        w_run = 1'b1;
        if (w_waitDone) begin
          if (w_nextValid) begin
            w_step = 1'b1;
          end else begin
            w_stateNext = ST_DONE;
          end
        end
      end
      ST_DONE: w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_be   <= '0;
      r_wren <= 1'b0;
    end else if (w_accept) begin
      r_addr <= address_bus;
      r_data <= data_bus;
      r_be   <= byteena_bus;
      r_wren <= wren_bus;
    end
  end

  // Only the lane of the beat finishing its strobe is updated; others hold.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if ((r_state == ST_BEAT) && !r_wren && w_waitDone) begin
      for (int g = 0; g < RATIO; g++) begin
        if (w_beat == IDX_W'(g)) begin
          r_q[g*RAM_W +: RAM_W] <= q_ram;
        end
      end
    end
  end

  always_comb begin
    w_dataLane = '0;
    w_beLane   = '0;
    for (int g = 0; g < RATIO; g++) begin
      if (w_beat == IDX_W'(g)) begin
        w_dataLane = r_data[g*RAM_W +: RAM_W];
        w_beLane   = r_be[g*LANE_B +: LANE_B];
      end
    end
  end

  always_comb begin
    ce_ram      = 1'b1;
    oe_ram      = 1'b1;
    wren_ram    = 1'b1;
    data_oe_tri = 1'b0;
    byteena_ram = '1;
    data_ram    = '0;
    if (r_state == ST_BEAT) begin
      ce_ram = 1'b0;
      if (r_wren) begin
        wren_ram    = 1'b0;
        data_oe_tri = 1'b1;
        data_ram    = w_dataLane;
        byteena_ram = ~w_beLane;
      end else begin
        oe_ram      = 1'b0;
        byteena_ram = '0;
      end
    end
  end

  if (BEAT_W == 0) begin : g_addrFlat
    assign address_ram = r_addr;
  end else begin : g_addrBeat
    assign address_ram = {r_addr, w_beat};
  end

  assign q_bus    = r_q;
  assign wait_bus = ce_bus & (r_state != ST_DONE);

endmodule
